tda_config_regfile: RTL and testbench

//  Responder for the host config bus (config_addr/config_data/config_wr_en) of the KAN/TDA ASIC.

---
 rtl/tda_cfg_pkg.sv | 46 ++++
 rtl/tda_coeff_streamer.sv | 105 ++++++++++
 rtl/tda_config_regfile.sv | 159 +++++++++++++++
 tb/tb_tda_config_regfile.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tda_cfg_pkg.sv
// Shared constants for the KAN/TDA config responder: address map, reset defaults,
// sequencer state encoding and status bit positions.
package tda_cfg_pkg;

   localparam int DATA_WIDTH_DEF  = 32;
   localparam int ADDR_WIDTH_DEF  = 16;
   localparam int COEFF_WIDTH_DEF = 24;
   localparam int NUM_COEFF_DEF   = 16;
   localparam int NUM_PARAM       = 16;
   localparam int START_TMO_DEF   = 4;

   localparam logic [15:0] COEFF_BASE = 16'h0000;
   localparam logic [15:0] PARAM_BASE = 16'h8000;
   localparam logic [15:0] CTRL_ADDR  = 16'hF000;

   localparam int CTRL_GO_BIT    = 0;
   localparam int CTRL_CLEAR_BIT = 1;

   localparam logic [31:0] EPSILON_RST    = 32'h0000_1000;
   localparam logic [31:0] NUM_POINTS_RST = 32'd16;
   localparam logic [31:0] DIMENSION_RST  = 32'd2;

   localparam int STAT_IDLE_BIT   = 0;
   localparam int STAT_STREAM_BIT = 1;
   localparam int STAT_WAIT_BIT   = 2;
   localparam int STAT_ERR_BIT    = 3;
   localparam int STAT_TRUNC_BIT  = 4;

   typedef enum logic [1:0] {
      CFG_IDLE   = 2'd0,
      CFG_STREAM = 2'd1,
      CFG_START  = 2'd2,
      CFG_WAIT   = 2'd3
   } cfg_state_e;

   // Parameter slot 0 is epsilon, 1 is num_points, 2 is dimension; the rest clear to zero.
   function automatic logic [31:0] param_reset_val(input int idx);
      case (idx)
         0:       return EPSILON_RST;
         1:       return NUM_POINTS_RST;
         2:       return DIMENSION_RST;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/tda_coeff_streamer.sv
// Coefficient stream sequencer: walks the bank index over valid/ready, fires start,
// then waits for the cores to report done (busy fall) or times out.
//
//   state      | meaning
//   CFG_IDLE   | nothing in flight, waiting for GO
//   CFG_STREAM | coeff_valid high, idx advances on each valid&ready beat
//   CFG_START  | one-cycle start_pulse after the last beat
//   CFG_WAIT   | waiting for core_busy to rise then fall, or for the start timeout
module tda_coeff_streamer
   import tda_cfg_pkg::*;
#(
   parameter int NUM_COEFF = NUM_COEFF_DEF,
   parameter int START_TMO = START_TMO_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic       clear,
   input  logic       coeff_ready,
   input  logic       core_busy,
   output logic       coeff_valid,
   output logic [3:0] coeff_idx,
   output logic       start_pulse,
   output cfg_state_e state,
   output logic       tmo_err
);

   localparam int               TMR_W    = $clog2(START_TMO + 1);
   localparam logic [3:0]       LAST_IDX = 4'(NUM_COEFF - 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(START_TMO);
   localparam logic [TMR_W-1:0] TMR_TC   = TMR_W'(1);

   cfg_state_e       state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             seen_q, seen_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CFG_IDLE;
         idx_q   <= '0;
         tmr_q   <= '0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         seen_q  <= seen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      seen_d  = seen_q;
      tmo_err = 1'b0;
      if (clear) begin
         state_d = CFG_IDLE;
         idx_d   = '0;
         tmr_d   = '0;
         seen_d  = 1'b0;
      end else begin
         case (state_q)
            CFG_IDLE: begin
               if (go) begin
                  state_d = CFG_STREAM;
                  idx_d   = '0;
               end
            end
            CFG_STREAM: begin
               if (coeff_ready) begin
                  idx_d = 4'(idx_q + 4'd1);
                  if (idx_q == LAST_IDX) state_d = CFG_START;
               end
            end
            CFG_START: begin
               state_d = CFG_WAIT;
               tmr_d   = TMR_LOAD;
               seen_d  = 1'b0;
            end
            CFG_WAIT: begin
               // Timer only runs until busy is first seen; after that we wait for the fall.
               if (seen_q) begin
                  if (!core_busy) state_d = CFG_IDLE;
               end else if (core_busy) begin
                  seen_d = 1'b1;
               end else if (tmr_q == TMR_TC) begin
                  state_d = CFG_IDLE;
                  tmo_err = 1'b1;
               end else begin
                  tmr_d = tmr_q - TMR_TC;
               end
            end
            default: state_d = CFG_IDLE;
         endcase
      end
   end

   assign coeff_valid = (state_q == CFG_STREAM);
   assign start_pulse = (state_q == CFG_START);
   assign coeff_idx   = idx_q;
   assign state       = state_q;

endmodule

// File: rtl/tda_config_regfile.sv
// Host config-bus responder: coefficient shadow bank, TDA parameters, GO/CLEAR control.
// Define CFG_READBACK_EN to add the registered readback port (cfg_rd_en/cfg_rd_addr/cfg_rd_data).
module tda_config_regfile
   import tda_cfg_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
   parameter int NUM_COEFF   = NUM_COEFF_DEF,
   parameter int START_TMO   = START_TMO_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  config_addr,
   input  logic [DATA_WIDTH-1:0]  config_data,
   input  logic                   config_wr_en,
   output logic                   config_err,
   output logic [COEFF_WIDTH-1:0] coeff_data,
   output logic [3:0]             coeff_idx,
   output logic                   coeff_valid,
   input  logic                   coeff_ready,
   output logic [DATA_WIDTH-1:0]  epsilon,
   output logic [7:0]             num_points,
   output logic [7:0]             dimension,
   output logic                   start_pulse,
   input  logic                   core_busy,
   output logic                   cfg_busy,
   output logic [7:0]             status
`ifdef CFG_READBACK_EN
   ,
   input  logic                   cfg_rd_en,
   input  logic [ADDR_WIDTH-1:0]  cfg_rd_addr,
   output logic [DATA_WIDTH-1:0]  cfg_rd_data
`endif
);

   localparam logic [ADDR_WIDTH-1:0] A_COEFF = ADDR_WIDTH'(COEFF_BASE);
   localparam logic [ADDR_WIDTH-1:0] A_PARAM = ADDR_WIDTH'(PARAM_BASE);
   localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(CTRL_ADDR);

   cfg_state_e state;
   logic       tmo_err;
   logic       coeff_hit, param_hit, ctrl_hit, busy;
   logic       go, clear, reject, unmapped, wr_ok;

   logic [NUM_COEFF-1:0][COEFF_WIDTH-1:0] coeff_q, coeff_d;
   logic [NUM_PARAM-1:0][DATA_WIDTH-1:0]  param_q, param_d;
   logic err_q, err_d, trunc_q, trunc_d, config_err_q, config_err_d;

   assign coeff_hit = (config_addr[ADDR_WIDTH-1:4] == A_COEFF[ADDR_WIDTH-1:4]);
   assign param_hit = (config_addr[ADDR_WIDTH-1:4] == A_PARAM[ADDR_WIDTH-1:4]);
   assign ctrl_hit  = (config_addr == A_CTRL);
   assign busy      = (state != CFG_IDLE);

   assign clear    = config_wr_en && ctrl_hit && config_data[CTRL_CLEAR_BIT];
   assign go       = config_wr_en && ctrl_hit && config_data[CTRL_GO_BIT]
                     && !config_data[CTRL_CLEAR_BIT] && !busy;
   assign reject   = config_wr_en && busy && (coeff_hit || param_hit
                     || (ctrl_hit && config_data[CTRL_GO_BIT] && !config_data[CTRL_CLEAR_BIT]));
   assign unmapped = config_wr_en && !(coeff_hit || param_hit || ctrl_hit);
   assign wr_ok    = config_wr_en && !busy;

   tda_coeff_streamer #(
      .NUM_COEFF (NUM_COEFF),
      .START_TMO (START_TMO)
   ) u_streamer (
      .clk         (clk),
      .rst_n       (rst_n),
      .go          (go),
      .clear       (clear),
      .coeff_ready (coeff_ready),
      .core_busy   (core_busy),
      .coeff_valid (coeff_valid),
      .coeff_idx   (coeff_idx),
      .start_pulse (start_pulse),
      .state       (state),
      .tmo_err     (tmo_err)
   );

   always_comb begin
      coeff_d      = coeff_q;
      param_d      = param_q;
      err_d        = err_q;
      trunc_d      = trunc_q;
      config_err_d = 1'b0;
      if (clear) begin
         coeff_d = '0;
         for (int i = 0; i < NUM_PARAM; i++) param_d[i] = DATA_WIDTH'(param_reset_val(i));
         err_d   = 1'b0;
         trunc_d = 1'b0;
      end else begin
         if (tmo_err) err_d = 1'b1;
         if (go) begin
            err_d   = 1'b0;
            trunc_d = 1'b0;
         end
         if (unmapped || reject) begin
            err_d        = 1'b1;
            config_err_d = 1'b1;
         end
         if (wr_ok && coeff_hit) begin
            coeff_d[config_addr[3:0]] = config_data[COEFF_WIDTH-1:0];
            if (|config_data[DATA_WIDTH-1:COEFF_WIDTH]) trunc_d = 1'b1;
         end
         if (wr_ok && param_hit) param_d[config_addr[3:0]] = config_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coeff_q <= '0;
         for (int i = 0; i < NUM_PARAM; i++) param_q[i] <= DATA_WIDTH'(param_reset_val(i));
         err_q        <= 1'b0;
         trunc_q      <= 1'b0;
         config_err_q <= 1'b0;
      end else begin
         coeff_q      <= coeff_d;
         param_q      <= param_d;
         err_q        <= err_d;
         trunc_q      <= trunc_d;
         config_err_q <= config_err_d;
      end
   end

   assign config_err = config_err_q;
   assign coeff_data = coeff_valid ? coeff_q[coeff_idx] : '0;
   assign epsilon    = param_q[0];
   assign num_points = param_q[1][7:0];
   assign dimension  = param_q[2][7:0];
   assign cfg_busy   = busy;
   assign status     = {3'b000, trunc_q, err_q, state == CFG_WAIT,
                        state == CFG_STREAM, state == CFG_IDLE};

`ifdef CFG_READBACK_EN
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   // Reads sample the registered contents, so a same-cycle write is seen on the next read.
   always_comb begin
      rd_data_d = rd_data_q;
      if (cfg_rd_en) begin
         rd_data_d = '0;
         if (cfg_rd_addr[ADDR_WIDTH-1:4] == A_COEFF[ADDR_WIDTH-1:4])
            rd_data_d = DATA_WIDTH'(coeff_q[cfg_rd_addr[3:0]]);
         else if (cfg_rd_addr[ADDR_WIDTH-1:4] == A_PARAM[ADDR_WIDTH-1:4])
            rd_data_d = param_q[cfg_rd_addr[3:0]];
         else if (cfg_rd_addr == A_CTRL)
            rd_data_d = DATA_WIDTH'(status);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign cfg_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_tda_config_regfile.sv
// Bench for tda_config_regfile: directed vector table, hand sequences for streaming,
// stalls, rejects, timeout, CLEAR and async reset, then randomized ops against a model.
module tb_tda_config_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] config_addr;
   logic [31:0] config_data;
   logic        config_wr_en;
   logic        config_err;
   logic [23:0] coeff_data;
   logic [3:0]  coeff_idx;
   logic        coeff_valid;
   logic        coeff_ready;
   logic [31:0] epsilon;
   logic [7:0]  num_points;
   logic [7:0]  dimension;
   logic        start_pulse;
   logic        core_busy;
   logic        cfg_busy;
   logic [7:0]  status;

   int n_checks = 0;
   int n_pass   = 0;

   logic [23:0] m_coeff [16];
   logic [31:0] m_param [16];
   logic        m_err, m_trunc;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      logic        exp_err;
      logic [31:0] exp_eps;
      logic [7:0]  exp_np;
      logic [7:0]  exp_dim;
      logic [7:0]  exp_st;
   } vec_t;

   vec_t vecs [12];

   always #5 clk = ~clk;

   tda_config_regfile dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .config_addr  (config_addr),
      .config_data  (config_data),
      .config_wr_en (config_wr_en),
      .config_err   (config_err),
      .coeff_data   (coeff_data),
      .coeff_idx    (coeff_idx),
      .coeff_valid  (coeff_valid),
      .coeff_ready  (coeff_ready),
      .epsilon      (epsilon),
      .num_points   (num_points),
      .dimension    (dimension),
      .start_pulse  (start_pulse),
      .core_busy    (core_busy),
      .cfg_busy     (cfg_busy),
      .status       (status)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [31:0] data);
      config_addr  = addr;
      config_data  = data;
      config_wr_en = 1'b1;
      step();
      config_wr_en = 1'b0;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_coeff[i] = '0;
         m_param[i] = '0;
      end
      m_param[0] = 32'h1000;
      m_param[1] = 32'd16;
      m_param[2] = 32'd2;
      m_err      = 1'b0;
      m_trunc    = 1'b0;
   endtask

   function automatic bit m_mapped(input logic [15:0] addr);
      return (addr < 16'h0010) || (addr >= 16'h8000 && addr <= 16'h800F) || (addr == 16'hF000);
   endfunction

   function automatic logic [7:0] m_status(input logic [2:0] st_bits);
      return {3'b000, m_trunc, m_err, st_bits};
   endfunction

   // Model of a write accepted while idle (GO is handled by the caller).
   task automatic m_write_idle(input logic [15:0] addr, input logic [31:0] data);
      if (addr < 16'h0010) begin
         m_coeff[addr[3:0]] = data[23:0];
         if (data[31:24] != 8'h00) m_trunc = 1'b1;
      end else if (addr >= 16'h8000 && addr <= 16'h800F) begin
         m_param[addr[3:0]] = data;
      end else if (addr == 16'hF000) begin
         if (data[1]) m_reset();
         else if (data[0]) begin
            m_err   = 1'b0;
            m_trunc = 1'b0;
         end
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, "_eps"}, epsilon, m_param[0]);
      chk({tag, "_np"},  {24'h0, num_points}, {24'h0, m_param[1][7:0]});
      chk({tag, "_dim"}, {24'h0, dimension},  {24'h0, m_param[2][7:0]});
   endtask

   // Entered on the first cycle after GO; returns on the start_pulse cycle.
   task automatic stream_check(input int mode, input string tag);
      int         beats = 0;
      int         c;
      bit         got_start = 1'b0;
      bit         stalled = 1'b0;
      logic [3:0]  p_idx = '0;
      logic [23:0] p_data = '0;
      for (c = 0; c < 200; c++) begin
         if (start_pulse) begin
            got_start = 1'b1;
            break;
         end
         case (mode)
            0:       coeff_ready = 1'b1;
            1:       coeff_ready = ~coeff_ready;
            default: coeff_ready = 1'($urandom_range(0, 1));
         endcase
         if (mode == 0) chk({tag, "_valid"}, coeff_valid, 1);
         if (stalled) begin
            chk({tag, "_hold_idx"},  coeff_idx,  p_idx);
            chk({tag, "_hold_data"}, coeff_data, p_data);
         end
         if (coeff_valid && coeff_ready) begin
            chk({tag, "_idx"},  coeff_idx,  beats);
            chk({tag, "_data"}, coeff_data, m_coeff[beats % 16]);
            beats++;
         end
         stalled = coeff_valid && !coeff_ready;
         p_idx   = coeff_idx;
         p_data  = coeff_data;
         step();
      end
      chk({tag, "_start_seen"}, got_start, 1);
      chk({tag, "_beats"}, beats, 16);
      if (mode == 0) chk({tag, "_start_cycle"}, c, 16);
      chk({tag, "_valid_at_start"}, coeff_valid, 0);
   endtask

   // Entered on the start_pulse cycle; returns with the sequencer back in idle.
   task automatic wait_done(input bit busy_resp, input int delay, input int hold, input string tag);
      core_busy = 1'b0;
      step();
      chk({tag, "_pulse_once"}, start_pulse, 0);
      if (!busy_resp) begin
         for (int k = 0; k < 4; k++) begin
            chk({tag, "_waiting"}, status[2:0], 3'b100);
            step();
         end
         m_err = 1'b1;
      end else begin
         repeat (delay) step();
         core_busy = 1'b1;
         repeat (hold) step();
         chk({tag, "_busy_wait"}, status[2:0], 3'b100);
         core_busy = 1'b0;
         step();
      end
      chk({tag, "_idle_status"}, status, m_status(3'b001));
      chk({tag, "_idle_busy"}, cfg_busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] addr;
      logic [31:0] data;
      int          r;
      int          n_starts;

      rst_n        = 1'b0;
      config_addr  = '0;
      config_data  = '0;
      config_wr_en = 1'b0;
      coeff_ready  = 1'b0;
      core_busy    = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      chk("in_reset_status", status, 8'h01);
      chk("in_reset_valid", coeff_valid, 0);
      rst_n = 1'b1;
      step();

      // Reset values
      chk("rst_status", status, 8'h01);
      chk("rst_eps", epsilon, 32'h1000);
      chk("rst_np", num_points, 8'd16);
      chk("rst_dim", dimension, 8'd2);
      chk("rst_valid", coeff_valid, 0);
      chk("rst_start", start_pulse, 0);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_err", config_err, 0);
      chk("rst_data", coeff_data, 0);

      // Directed decode table, applied from reset in idle
      vecs[0]  = '{16'h8000, 32'h0000ABCD, 1'b0, 32'hABCD, 8'h10, 8'h02, 8'h01};
      vecs[1]  = '{16'h4000, 32'h00000001, 1'b1, 32'hABCD, 8'h10, 8'h02, 8'h09};
      vecs[2]  = '{16'h8001, 32'h00001234, 1'b0, 32'hABCD, 8'h34, 8'h02, 8'h09};
      vecs[3]  = '{16'h8002, 32'h0000FF05, 1'b0, 32'hABCD, 8'h34, 8'h05, 8'h09};
      vecs[4]  = '{16'h0003, 32'h01000000, 1'b0, 32'hABCD, 8'h34, 8'h05, 8'h19};
      vecs[5]  = '{16'hF000, 32'h00000000, 1'b0, 32'hABCD, 8'h34, 8'h05, 8'h19};
      vecs[6]  = '{16'h8010, 32'h00000005, 1'b1, 32'hABCD, 8'h34, 8'h05, 8'h19};
      vecs[7]  = '{16'h0010, 32'h00000005, 1'b1, 32'hABCD, 8'h34, 8'h05, 8'h19};
      vecs[8]  = '{16'hF001, 32'h00000001, 1'b1, 32'hABCD, 8'h34, 8'h05, 8'h19};
      vecs[9]  = '{16'hF000, 32'h00000002, 1'b0, 32'h1000, 8'h10, 8'h02, 8'h01};
      vecs[10] = '{16'hFFFF, 32'h00000000, 1'b1, 32'h1000, 8'h10, 8'h02, 8'h09};
      vecs[11] = '{16'hF000, 32'h00000003, 1'b0, 32'h1000, 8'h10, 8'h02, 8'h01};
      for (int v = 0; v < 12; v++) begin
         wr(vecs[v].addr, vecs[v].data);
         chk($sformatf("vec%0d_err", v), config_err, vecs[v].exp_err);
         chk($sformatf("vec%0d_eps", v), epsilon, vecs[v].exp_eps);
         chk($sformatf("vec%0d_np", v), num_points, vecs[v].exp_np);
         chk($sformatf("vec%0d_dim", v), dimension, vecs[v].exp_dim);
         chk($sformatf("vec%0d_status", v), status, vecs[v].exp_st);
      end
      m_reset();

      wr(16'h4000, 32'h0);
      chk("err_pulse_hi", config_err, 1);
      step();
      chk("err_pulse_lo", config_err, 0);
      wr(16'hF000, 32'h2);
      m_reset();

      // Full-rate stream
      for (int i = 0; i < 16; i++) begin
         wr(16'(i), 32'h1000 + 32'(i) * 32'h100);
         m_write_idle(16'(i), 32'h1000 + 32'(i) * 32'h100);
      end
      coeff_ready = 1'b1;
      wr(16'hF000, 32'h1);
      m_write_idle(16'hF000, 32'h1);
      chk("t2_busy", cfg_busy, 1);
      chk("t2_status", status, 8'h02);
      stream_check(0, "t2");
      wait_done(1'b1, 0, 2, "t2");

      // Stream with ready toggling every cycle
      wr(16'hF000, 32'h1);
      stream_check(1, "t3");
      wait_done(1'b1, 1, 1, "t3");

      // Writes while streaming are rejected
      coeff_ready = 1'b0;
      wr(16'hF000, 32'h1);
      wr(16'h8000, 32'h2000);
      m_err = 1'b1;
      chk("t4_param_err", config_err, 1);
      chk("t4_status", status, m_status(3'b010));
      chk("t4_eps", epsilon, 32'h1000);
      chk("t4_valid", coeff_valid, 1);
      chk("t4_idx", coeff_idx, 0);
      wr(16'h4000, 32'h1);
      chk("t4_unmapped_err", config_err, 1);
      wr(16'h0005, 32'h77);
      chk("t4_coeff_err", config_err, 1);
      wr(16'hF000, 32'h1);
      chk("t4_go_err", config_err, 1);
      stream_check(2, "t4");
      wait_done(1'b0, 0, 0, "t4");

      // Truncation sticky, cleared by GO; then start timeout
      wr(16'h0000, 32'hFF123456);
      m_write_idle(16'h0000, 32'hFF123456);
      chk("t5_trunc_status", status, m_status(3'b001));
      chk("t5_trunc_bit", status[4], 1);
      wr(16'hF000, 32'h1);
      m_write_idle(16'hF000, 32'h1);
      chk("t5_go_clears", status, 8'h02);
      coeff_ready = 1'b1;
      stream_check(0, "t5");
      wait_done(1'b0, 0, 0, "t6");
      chk("t6_err_bit", status[3], 1);

      // CLEAR (with GO) mid-stream
      wr(16'hF000, 32'h1);
      m_write_idle(16'hF000, 32'h1);
      repeat (5) step();
      wr(16'hF000, 32'h3);
      m_reset();
      chk("t6_clr_valid", coeff_valid, 0);
      chk("t6_clr_status", status, 8'h01);
      chk("t6_clr_busy", cfg_busy, 0);
      chk_regs("t6_clr");
      n_starts = 0;
      for (int k = 0; k < 20; k++) begin
         if (start_pulse) n_starts++;
         step();
      end
      chk("t6_clr_no_start", n_starts, 0);
      wr(16'hF000, 32'h1);
      stream_check(0, "t6_zero");
      wait_done(1'b1, 0, 1, "t6_zero");

      // Async reset mid-stream
      wr(16'h0007, 32'h00ABCDEF);
      wr(16'hF000, 32'h1);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", coeff_valid, 0);
      chk("async_status", status, 8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      step();
      chk_regs("async");

      // Randomized ops against the model
      for (int op = 0; op < 150; op++) begin
         r = $urandom_range(0, 9);
         addr = 16'h0;
         data = $urandom;
         case (r)
            0, 1, 2, 3: begin
               addr = 16'($urandom_range(0, 15));
               if ($urandom_range(0, 3) != 0) data = data & 32'h00FF_FFFF;
            end
            4, 5: addr = 16'h8000 + 16'($urandom_range(0, 15));
            6: begin
               addr = 16'($urandom);
               data = data & ~32'h1;
            end
            7: begin
               addr = 16'hF000;
               data = data & ~32'h3;
            end
            8: begin
               addr = 16'hF000;
               data = data | 32'h2;
            end
            default: begin
               addr = 16'hF000;
               data = 32'h1;
            end
         endcase
         if (r == 9) begin
            wr(addr, data);
            m_write_idle(addr, data);
            chk("rnd_go_status", status, 8'h02);
            stream_check(2, "rnd");
            if ($urandom_range(0, 3) == 0) wait_done(1'b0, 0, 0, "rnd_tmo");
            else wait_done(1'b1, $urandom_range(0, 3), $urandom_range(1, 3), "rnd_done");
         end else begin
            wr(addr, data);
            chk("rnd_err", config_err, !m_mapped(addr));
            m_write_idle(addr, data);
            chk_regs("rnd");
            chk("rnd_status", status, m_status(3'b001));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
